// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed common-anode hex display driver with frame-aligned double buffering.
// Optional leading-zero suppression is compiled in with `define SEVEN_SEG_LZS_EN.
module seven_seg_scan_driver #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   digits_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_in,
  output logic [6:0]            seg,
  output logic                  dp_n,
  output logic [DIGITS-1:0]     an_n,
  output logic                  frame_done
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [6:0]    SEG_OFF    = 7'b1111111;

  // Segment pattern {A..G}, active-low.
  function automatic logic [6:0] hex_decode(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  slot_end, frame_end;

  logic [4*DIGITS-1:0]   shd_dig_q, shd_dig_d;
  logic [DIGITS-1:0]     shd_dp_q, shd_dp_d;
  logic [DIGITS-1:0]     shd_bl_q, shd_bl_d;
  logic                  pend_q, pend_d;

  logic [4*DIGITS-1:0]   dsp_dig_q, dsp_dig_d;
  logic [DIGITS-1:0]     dsp_dp_q, dsp_dp_d;
  logic [DIGITS-1:0]     dsp_bl_q, dsp_bl_d;

  logic [DIGITS-1:0]     lzs;
  logic                  guard;
  logic [3:0]            cur_code;
  logic                  cur_dp;
  logic                  cur_blank;

  logic [6:0]            seg_q, seg_d;
  logic                  dp_n_q, dp_n_d;
  logic [DIGITS-1:0]     an_n_q, an_n_d;
  logic                  fd_q, fd_d;

  // Scan timebase: prescaler within a slot, index across slots.
  always_comb begin
    slot_end  = (presc_q == PRESC_LAST);
    frame_end = slot_end && (idx_q == IDX_LAST);
    presc_d   = slot_end ? '0 : presc_q + PW'(1);
    idx_d     = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end
  end

  // A load on the boundary cycle bypasses the shadow so it is never a frame late.
  always_comb begin
    shd_dig_d = shd_dig_q;
    shd_dp_d  = shd_dp_q;
    shd_bl_d  = shd_bl_q;
    pend_d    = pend_q;
    dsp_dig_d = dsp_dig_q;
    dsp_dp_d  = dsp_dp_q;
    dsp_bl_d  = dsp_bl_q;
    if (load) begin
      shd_dig_d = digits_in;
      shd_dp_d  = dp_in;
      shd_bl_d  = blank_in;
      pend_d    = 1'b1;
    end
    if (frame_end) begin
      if (load) begin
        dsp_dig_d = digits_in;
        dsp_dp_d  = dp_in;
        dsp_bl_d  = blank_in;
        pend_d    = 1'b0;
      end else if (pend_q) begin
        dsp_dig_d = shd_dig_q;
        dsp_dp_d  = shd_dp_q;
        dsp_bl_d  = shd_bl_q;
        pend_d    = 1'b0;
      end
    end
  end

`ifdef SEVEN_SEG_LZS_EN
  // Suppression runs from the MSB down and stops at the first non-zero code or lit dp.
  always_comb begin
    logic run;
    lzs = '0;
    run = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (run && (dsp_dig_q[4*i +: 4] == 4'h0) && !dsp_dp_q[i]) begin
        lzs[i] = 1'b1;
      end else begin
        run = 1'b0;
      end
    end
  end
`else
  assign lzs = '0;
`endif

  always_comb begin
    cur_code  = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_code  = dsp_dig_q[4*i +: 4];
        cur_dp    = dsp_dp_q[i];
        cur_blank = dsp_bl_q[i] | lzs[i];
      end
    end
  end

  generate
    if (BLANK_CYC > 0) begin : g_guard
      assign guard = (presc_q < PW'(BLANK_CYC));
    end else begin : g_no_guard
      assign guard = 1'b0;
    end
  endgenerate

  // Output stage: everything pin-facing is registered one cycle behind the scan state.
  always_comb begin
    seg_d  = SEG_OFF;
    dp_n_d = 1'b1;
    an_n_d = '1;
    fd_d   = frame_end;
    if (!guard) begin
      for (int i = 0; i < DIGITS; i++) begin
        an_n_d[i] = (idx_q != IW'(i));
      end
      if (!cur_blank) begin
        seg_d  = hex_decode(cur_code);
        dp_n_d = ~cur_dp;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q   <= '0;
      idx_q     <= '0;
      shd_dig_q <= '0;
      shd_dp_q  <= '0;
      shd_bl_q  <= '0;
      pend_q    <= 1'b0;
      dsp_dig_q <= '0;
      dsp_dp_q  <= '0;
      dsp_bl_q  <= '0;
      seg_q     <= SEG_OFF;
      dp_n_q    <= 1'b1;
      an_n_q    <= '1;
      fd_q      <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      shd_dig_q <= shd_dig_d;
      shd_dp_q  <= shd_dp_d;
      shd_bl_q  <= shd_bl_d;
      pend_q    <= pend_d;
      dsp_dig_q <= dsp_dig_d;
      dsp_dp_q  <= dsp_dp_d;
      dsp_bl_q  <= dsp_bl_d;
      seg_q     <= seg_d;
      dp_n_q    <= dp_n_d;
      an_n_q    <= an_n_d;
      fd_q      <= fd_d;
    end
  end

  assign seg        = seg_q;
  assign dp_n       = dp_n_q;
  assign an_n       = an_n_q;
  assign frame_done = fd_q;

endmodule

// File: doc/seven_seg_scan_driver.md
# seven_seg_scan_driver

Time-multiplexed driver for a DIGITS-wide common-anode hex seven-segment display, parametrised in digit count and refresh rate. It accepts a packed word of 4-bit digit codes plus decimal-point and blank masks. Loaded values are double-buffered so updates land only on frame boundaries. It scans one digit per refresh slot with an anti-ghosting blank window, and sits between the stopwatch/counter datapath and the board display pins.

## Interface
- DIGITS, 4, number of digits scanned; legal range 1..8
- REFRESH_DIV, 50000, clock cycles per digit slot; must be ≥ 2
- BLANK_CYC, 2, cycles at the start of each slot with all anodes off; must be < REFRESH_DIV
- clk  input  1  single system clock, rising edge
- reset  input  1  synchronous, active-high reset
- load  input  1  one-cycle strobe; captures digits_in, dp_in and blank_in into the shadow register
- digits_in  input  4*DIGITS  digit codes; digit 0 = bits [3:0], least significant/rightmost
- dp_in  input  DIGITS  decimal point request per digit, 1 = lit
- blank_in  input  DIGITS  force digit dark, 1 = blank
- seg  output  7  segments {A,B,C,D,E,F,G}, A = MSB, active-low
- dp_n  output  1  decimal point, active-low
- an_n  output  DIGITS  anode enables, active-low, at most one low
- frame_done  output  1  one-cycle pulse when the scan wraps from DIGITS-1 to 0

## Operation
- **Prescaler** counts 0..REFRESH_DIV-1 and then wraps. At the terminal count, the digit index advances.
  - The index wraps from DIGITS-1 to 0. That wrap is the frame boundary.
- **Shadow register:**
  - load writes the shadow register and sets pending.
  - At the frame boundary, if pending is set, shadow is copied to the display register and pending clears.
  - A later load before the boundary overwrites shadow; the last one wins.
- **load coinciding with the frame boundary:** the new data is committed at that boundary directly and pending stays clear.
- **Decode**, per 4-bit code, as seg patterns {A..G}:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- **Blanked digit:** seg=1111111 and dp_n=1. The anode is still driven, so the scan timing is unchanged.
- **Ghost guard:** while prescaler < BLANK_CYC, an_n is all ones and seg=1111111.
- **Active slot:** an_n has a single low bit at the current index.
- **Reset** (synchronous, mid-operation included): clears prescaler, index, display register, shadow register and pending.
  - Outputs after reset: seg=1111111, dp_n=1, an_n=all ones, frame_done=0.
  - After reset, the display shows 0 on all digits, since the display register is zero and unblanked, once slots begin.

## Timing
- All outputs are registered. Each output reflects the prescaler/index state of the previous cycle, i.e. one cycle of latency.
- Slot k (index k) drives an_n[k]=0 from cycle BLANK_CYC+1 through cycle REFRESH_DIV of that slot. Cycles are counted from the slot's prescaler=0 cycle.
- Frame period is DIGITS*REFRESH_DIV cycles.
- frame_done is high for exactly one cycle: the cycle after the prescaler=REFRESH_DIV-1, index=DIGITS-1 cycle.
- Load-to-visible latency is at most DIGITS*REFRESH_DIV+1 cycles. There is never a partial-frame update.
- DIGITS=1: every slot end is a frame boundary, so frame_done pulses every REFRESH_DIV cycles.

## Configuration
- SEVEN_SEG_LZS_EN defined: leading-zero suppression is enabled.
  - Any digit whose code is 0 and whose more-significant digits are all 0 is treated as blanked.
  - Digit 0 is never suppressed.
  - A digit with dp set is not suppressed and stops suppression below it.
  - Evaluation uses the display register.
- SEVEN_SEG_LZS_EN undefined: every digit not masked by blank_in is shown, including leading zeros.

## Test plan
- DIGITS=4, REFRESH_DIV=4, BLANK_CYC=1; reset held 3 cycles, then released.
  - Required: seg=1111111, an_n=1111 during reset.
  - Required after release: an_n sequence 1111, 1110, 1110, 1110, then 1111, 1101, ...
  - Required: seg=0000001 in lit cycles.
  - Required: frame_done pulses every 16 cycles.
- load digits_in=16'h12AF, dp_in=4'b0100 mid-frame.
  - Required: the remaining slots of the current frame still show 0.
  - Required next frame: digit0 seg=0111000, digit1 seg=0001000, digit2 seg=0010010 with dp_n=0, digit3 seg=1001111.
- Two loads in one frame (16'h1111, then 16'h2222), then load asserted on the frame-boundary cycle with 16'h3333.
  - Required: no frame ever displays 1111.
  - Required: 3333 is displayed in the frame starting at that boundary.
- blank_in=4'b1010 with digits 16'h8888.
  - Required: digits 1 and 3 show seg=1111111 and dp_n=1 while their anodes still go low in sequence.
  - Required: digits 0 and 2 show 0000000.
- With SEVEN_SEG_LZS_EN, load 16'h0050.
  - Required: digits 3 and 2 are blank; digit1 shows 0100100, digit0 shows 0000001.
  - Required without the macro: digits 3 and 2 show 0000001.
- Reset asserted while index=2 with pending load.
  - Required: next cycle all outputs are at reset values.
  - Required: pending data is discarded and all digits show 0 afterwards.
